// File: rtl/seg7_readback_if.sv
// Display-bus readback interface: multiplexed active-low segments in,
// assembled hex word and status out.
interface seg7_readback_if #(
   parameter int DIGITS = 4
);
   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   dig_sel;
   logic [4*DIGITS-1:0] value;
   logic                value_valid;
   logic [DIGITS-1:0]   digit_err;
   logic                overrun;

   modport master (
      output seg_n, dig_sel,
      input  value, value_valid, digit_err, overrun
   );

   modport slave (
      input  seg_n, dig_sel,
      output value, value_valid, digit_err, overrun
   );
endinterface

// File: rtl/seg7_readback_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus, filters
// unstable samples and assembles one word per complete digit scan.
module seg7_readback_decoder #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CYC = 4
) (
   input logic            clk,
   input logic            rst,
   seg7_readback_if.slave bus
);
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
   localparam logic [7:0] CNT_ARM = 8'(STABLE_CYC - 2);

   logic [6:0]              r_seg;
   logic [DIGITS-1:0]       r_sel;
   logic [7:0]              r_cnt;
   logic [DIGITS-1:0]       r_mask;
   logic [DIGITS-1:0][3:0]  r_slot;
   logic [DIGITS-1:0]       r_err;
   logic [4*DIGITS-1:0]     r_value;
   logic                    r_valid;
   logic [DIGITS-1:0]       r_derr;
   logic                    r_ovr;

   logic       w_changed;
   logic       w_onehot;
   logic       w_cap;
   logic       w_full;
   logic [6:0] w_pat;
   logic [3:0] w_nib;
   logic       w_hit;

   // Compare the incoming sample with the one already held, so the counter
   // restarts on the same edge that registers a new pattern.
   assign w_changed = ({bus.seg_n, bus.dig_sel} != {r_seg, r_sel});
   assign w_onehot  = (r_sel != '0) && ((r_sel & (r_sel - DIGITS'(1))) == '0);
   assign w_cap     = !w_changed && (r_cnt == CNT_ARM) && w_onehot;
   assign w_full    = &r_mask;
   assign w_pat     = ~r_seg;

   always_comb begin
      w_nib = 4'h0;
      w_hit = 1'b1;
      case (w_pat)
         7'h7E: w_nib = 4'h0;
         7'h30: w_nib = 4'h1;
         7'h6D: w_nib = 4'h2;
         7'h79: w_nib = 4'h3;
         7'h33: w_nib = 4'h4;
         7'h5B: w_nib = 4'h5;
         7'h5F: w_nib = 4'h6;
         7'h70: w_nib = 4'h7;
         7'h7F: w_nib = 4'h8;
         7'h7B: w_nib = 4'h9;
         7'h77: w_nib = 4'hA;
         7'h1F: w_nib = 4'hB;
         7'h4E: w_nib = 4'hC;
         7'h3D: w_nib = 4'hD;
         7'h4F: w_nib = 4'hE;
         7'h47: w_nib = 4'hF;
         default: begin
            w_nib = 4'h0;
            w_hit = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg   <= 7'h7F;
         r_sel   <= '0;
         r_cnt   <= 8'd0;
         r_mask  <= '0;
         r_slot  <= '0;
         r_err   <= '0;
         r_value <= '0;
         r_valid <= 1'b0;
         r_derr  <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_seg <= bus.seg_n;
         r_sel <= bus.dig_sel;

         if (w_changed)
            r_cnt <= 8'd0;
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 8'd1;

         r_valid <= w_full;
         if (w_full) begin
            r_value <= r_slot;
            r_derr  <= r_err;
         end

         // A capture on the delivery edge starts the next frame.
         r_mask <= (w_full ? '0 : r_mask) | (w_cap ? r_sel : '0);

         if (w_cap) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (r_sel[i]) begin
                  r_slot[i] <= w_nib;
                  r_err[i]  <= ~w_hit;
               end
            end
            if (!w_full && ((r_mask & r_sel) != '0))
               r_ovr <= 1'b1;
         end
      end
   end

   assign bus.value       = r_value;
   assign bus.value_valid = r_valid;
   assign bus.digit_err   = r_derr;
   assign bus.overrun     = r_ovr;
endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Scoreboard bench: expected frames are queued as stimulus is issued and a
// monitor compares them against each value_valid pulse.
module tb_seg7_readback_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_readback_if #(.DIGITS(4)) ifa ();
   seg7_readback_if #(.DIGITS(1)) ifb ();

   seg7_readback_decoder #(.DIGITS(4), .STABLE_CYC(4)) u_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   seg7_readback_decoder #(.DIGITS(1), .STABLE_CYC(4)) u_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   localparam logic [6:0] GLY [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   typedef struct {
      logic [15:0] v;
      logic [3:0]  e;
      logic        o;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic show_a(input logic [3:0] sel, input logic [6:0] pat, input int n);
      ifa.dig_sel = sel;
      ifa.seg_n   = ~pat;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show_b(input logic [6:0] pat, input int n);
      ifb.dig_sel = 1'b1;
      ifb.seg_n   = ~pat;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [15:0] v, input logic [3:0] e, input logic o);
      exp_t x;
      x.v = v; x.e = e; x.o = o;
      qa.push_back(x);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a_value"},   32'(ifa.value), 0);
      chk({tag, "_a_valid"},   32'(ifa.value_valid), 0);
      chk({tag, "_a_err"},     32'(ifa.digit_err), 0);
      chk({tag, "_a_overrun"}, 32'(ifa.overrun), 0);
      chk({tag, "_b_value"},   32'(ifb.value), 0);
      chk({tag, "_b_overrun"}, 32'(ifb.overrun), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifa.value_valid) begin
         if (qa.size() == 0) begin
            chk("unexpected_valid_a", 1, 0);
         end else begin
            e = qa.pop_front();
            chk("a_value",   32'(ifa.value), 32'(e.v));
            chk("a_err",     32'(ifa.digit_err), 32'(e.e));
            chk("a_overrun", 32'(ifa.overrun), 32'(e.o));
         end
      end
      if (!rst && ifb.value_valid) begin
         if (qb.size() == 0) begin
            chk("unexpected_valid_b", 1, 0);
         end else begin
            e = qb.pop_front();
            chk("b_value",   32'(ifb.value), 32'(e.v[3:0]));
            chk("b_err",     32'(ifb.digit_err), 32'(e.e[0]));
            chk("b_overrun", 32'(ifb.overrun), 0);
         end
      end
   end

   initial begin
      ifa.dig_sel = '0; ifa.seg_n = 7'h7F;
      ifb.dig_sel = '0; ifb.seg_n = 7'h7F;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // Basic frame: 3, A, 0, F
      push_a(16'hF0A3, 4'b0000, 1'b0);
      show_a(4'b0001, GLY[3], 8);
      show_a(4'b0010, GLY[10], 8);
      show_a(4'b0100, GLY[0], 8);
      show_a(4'b1000, GLY[15], 8);

      // Illegal glyph (g only) on digit 2
      push_a(16'h7021, 4'b0100, 1'b0);
      show_a(4'b0001, GLY[1], 8);
      show_a(4'b0010, GLY[2], 8);
      show_a(4'b0100, 7'h01, 8);
      show_a(4'b1000, GLY[7], 8);

      // Glitch filter: 3-cycle hold ignored, 4-cycle captured, 20-cycle once
      push_a(16'hDC86, 4'b0000, 1'b0);
      show_a(4'b0001, GLY[5], 3);
      show_a(4'b0000, GLY[5], 5);
      show_a(4'b0001, GLY[6], 4);
      show_a(4'b0010, GLY[8], 20);
      show_a(4'b0100, GLY[12], 8);
      show_a(4'b1000, GLY[13], 8);

      // Multi-hot select produces no capture
      push_a(16'h4321, 4'b0000, 1'b0);
      show_a(4'b0110, GLY[5], 10);
      show_a(4'b0001, GLY[1], 8);
      show_a(4'b0010, GLY[2], 8);
      show_a(4'b0100, GLY[3], 8);
      show_a(4'b1000, GLY[4], 8);

      // Digit 1 rewritten before the frame completes
      push_a(16'h3291, 4'b0000, 1'b1);
      show_a(4'b0010, GLY[5], 8);
      show_a(4'b0010, GLY[9], 8);
      show_a(4'b0001, GLY[1], 8);
      show_a(4'b0100, GLY[2], 8);
      show_a(4'b1000, GLY[3], 8);
      show_a(4'b0000, 7'h00, 6);

      // Mid-frame reset discards digits 0 and 1
      show_a(4'b0001, GLY[4], 8);
      show_a(4'b0010, GLY[5], 8);
      ifa.dig_sel = '0; ifa.seg_n = 7'h7F;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_zero("midreset");
      show_a(4'b0100, GLY[6], 8);
      show_a(4'b1000, GLY[7], 8);
      show_a(4'b0000, 7'h00, 10);
      push_a(16'h7698, 4'b0000, 1'b0);
      show_a(4'b0001, GLY[8], 8);
      show_a(4'b0010, GLY[9], 8);
      show_a(4'b0000, 7'h00, 10);
      chk("pending_a", 32'(qa.size()), 0);

      // Single-digit build: every glyph in order
      for (int i = 0; i < 16; i++) begin
         exp_t x;
         x.v = 16'(i); x.e = 4'b0000; x.o = 1'b0;
         qb.push_back(x);
         show_b(GLY[i], 8);
      end
      ifb.dig_sel = '0; ifb.seg_n = 7'h7F;
      repeat (20) @(posedge clk);
      #1;
      chk("pending_b", 32'(qb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_readback_decoder.md
Name: seg7_readback_decoder

Overview:
- Recovers hex digit values from a multiplexed, active-low 7-segment display bus; the inverse of the team's hex-to-segment driver.
- Samples segment lines plus a one-hot digit select, applies a stability filter, and decodes each stable pattern back to a 4-bit nibble.
- Assembles the nibbles of one full scan into a word and flags unrecognised patterns.
- Sits beside the calculator display path for self-check/readback of what is actually shown, and serves as a bench monitor.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYC, 4, consecutive identical samples required before a digit is accepted (2..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- seg_n  in  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- dig_sel  in  DIGITS  one-hot active-high digit strobe; bit i selects digit i, bit0 = least significant nibble
- value  out  4*DIGITS  assembled word; digit i occupies bits [4i+3:4i]
- value_valid  out  1  one-cycle pulse when value/digit_err are updated
- digit_err  out  DIGITS  bit i = digit i pattern was not a legal hex glyph in the frame just delivered
- overrun  out  1  sticky; a slot was rewritten before its frame completed; cleared by rst only

Behaviour:
- Input stage: seg_n and dig_sel are registered every edge (s_seg, s_sel). On reset: s_seg = 7'h7F (blank), s_sel = 0.
- Stability counter cnt (8 bits, saturating):
  - Cleared to 0 when the newly registered {s_seg, s_sel} differs from the previous registered value.
  - Otherwise increments, saturating at STABLE_CYC-1.
  - A capture strobe fires exactly once per stable window, on the edge where cnt goes from STABLE_CYC-2 to STABLE_CYC-1.
- Capture qualification:
  - A capture is performed only if s_sel is exactly one-hot.
  - All-zero or multi-hot s_sel: no capture, no error, counter behaviour unchanged.
- Decode: compare the active-high pattern p = ~s_seg against:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - A match writes the nibble into slot i and clears err_i. No match (including blank 00) writes 0 and sets err_i.
- Frame assembly:
  - A captured mask bit i is set on each capture into slot i.
  - If bit i is already set, the slot is overwritten (latest wins) and overrun is set.
  - On the edge after the mask becomes all-ones: value <= slots, digit_err <= err bits, value_valid = 1 for exactly one cycle, mask cleared.
  - A capture arriving on that same edge belongs to the new frame.
- Latency: a pattern held at the ports is registered at edge E0, and the slot is written at edge E0+STABLE_CYC-1. If this completes the frame, value_valid is high during the cycle after edge E0+STABLE_CYC.
- Reset behaviour:
  - Outputs after reset: value=0, value_valid=0, digit_err=0, overrun=0.
  - Internal state after reset: cnt=0, mask=0, slots=0.
  - Reset mid-frame discards partial captures; the first frame after reset needs all DIGITS captures.
- Glitch tolerance: any pattern or select change shorter than STABLE_CYC samples is never captured.

Test Plan:
- Basic frame: DIGITS=4, STABLE_CYC=4, drive digits 0..3 with glyphs 3,A,0,F (seg_n = ~79, ~77, ~7E, ~47), 8 cycles each -> single value_valid pulse, value = 16'hF0A3, digit_err = 0.
- All glyphs: cycle nibbles 0..F through digit 0 on a DIGITS=1 build -> 16 value_valid pulses with value = 0..F in order, digit_err = 0 throughout.
- Illegal pattern: digit 2 shows active-high 0x01 (g only), others legal glyphs -> value[11:8] = 0, digit_err = 4'b0100, overrun = 0.
- Glitch filter: a legal pattern held 3 cycles, then changed -> no capture. The same pattern held 4 cycles -> exactly one capture; holding it 20 cycles still gives only one capture.
- Bad select and overrun: dig_sel = 4'b0110 for 10 cycles -> no capture. Digit 1 shown twice (5, then 9) before digits 0, 2, 3 -> value[7:4] = 9, overrun = 1.
- Reset mid-frame: capture digits 0 and 1, assert rst for 1 cycle, then capture digits 2 and 3 only -> no value_valid. All outputs read 0 in the cycle after rst.
